// File: rtl/io_out_port_pkg.sv
// Shared types and constants for the CPU byte-output port and its serialiser.
package io_out_port_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Start bit, eight data bits and one stop bit.
  localparam int IO_FRAME_BITS           = 10;
  localparam int IO_DEFAULT_CLKS_PER_BIT = 16;
  localparam int IO_DEFAULT_DEPTH        = 8;

endpackage

// File: rtl/io_out_port_if.sv
// CPU-side byte-output bus: write strobe, data and overflow clear in, serial line and status out.
interface io_out_port_if
  import io_out_port_pkg::*;
#(
  parameter int DEPTH = IO_DEFAULT_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [7:0]       wr_data;
  logic             clr_ovf;
  logic             tx;
  logic             busy;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  tx, busy, full, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output tx, busy, full, count, overflow
  );

endinterface

// File: rtl/io_fifo.sv
// Synchronous byte FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module io_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q + PTR_W'(do_push);
    rptr_d  = rptr_q + PTR_W'(do_pop);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wptr_q] <= din;
    end
  end

endmodule

// File: rtl/io_out_port.sv
// CPU byte-output port: buffers written bytes and sends them as 8N1 frames, LSB first,
// with a sticky flag for bytes dropped while the buffer was full.
module io_out_port
  import io_out_port_pkg::*;
#(
  parameter int DEPTH        = IO_DEFAULT_DEPTH,
  parameter int CLKS_PER_BIT = IO_DEFAULT_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           reset,
  io_out_port_if.slave   bus
);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;

  logic              fifo_pop;
  logic [7:0]        fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  io_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.wr_en),
    .pop   (fifo_pop),
    .din   (bus.wr_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // tx_d is the line level for the cycle after the edge, so the line is glitch-free.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          bit_d    = '0;
          tx_d     = 1'b0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = TX_IDLE;
      end
    endcase

    // A drop in the same cycle as a clear must leave the flag set.
    if (bus.wr_en && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state_q != TX_IDLE) || !fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.count    = fifo_count;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_io_out_port.sv
// Self-checking bench for io_out_port: vector table, directed corner sequences and random
// traffic against a cycle-count model of the FIFO and frame timing, plus a tx line decoder.
module tb_io_out_port;
  import io_out_port_pkg::*;

  localparam int DEPTH = 8;
  localparam int CPB   = 4;
  localparam int FRAME = IO_FRAME_BITS * CPB;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  io_out_port_if #(.DEPTH(DEPTH)) bus ();

  io_out_port #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          rst;
    logic          wr;
    logic [7:0]    data;
    logic          clr;
    logic          exp_tx;
    logic          exp_busy;
    logic          exp_full;
    logic [CW-1:0] exp_count;
    logic          exp_ovf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of waiting bytes and cycles left in the current frame.
  logic [7:0] m_q[$];
  int         m_remain = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_ovf = 1'b0;
  logic [7:0] exp_frames[$];

  // Line decoder state.
  logic [7:0] rx_frames[$];
  logic       rx_active = 1'b0;
  int         rx_t0 = 0;
  int         cyc = 0;
  logic [9:0] rx_bits = '0;
  logic [9:0] last_bits = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic model_tx();
    int k;
    if (m_remain == 0) return 1'b1;
    k = (FRAME - m_remain) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic modelStep(input logic r, input logic w, input logic [7:0] d, input logic c);
    int sz;
    logic pop;
    logic evt;
    if (r) begin
      if (m_remain > 0) void'(exp_frames.pop_back());
      m_q.delete();
      m_remain = 0;
      m_ovf = 1'b0;
    end else begin
      sz  = m_q.size();
      pop = (m_remain == 0) && (sz > 0);
      evt = 1'b0;
      if (pop) begin
        m_byte = m_q.pop_front();
        exp_frames.push_back(m_byte);
        m_remain = FRAME;
      end else if (m_remain > 0) begin
        m_remain--;
      end
      if (w) begin
        if (sz < DEPTH || pop) m_q.push_back(d);
        else evt = 1'b1;
      end
      if (evt) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
    end
  endtask

  task automatic checkOutput();
    check("tx", bus.tx, model_tx());
    check("busy", bus.busy, (m_remain > 0) || (m_q.size() > 0));
    check("full", bus.full, m_q.size() == DEPTH);
    check("count", bus.count, m_q.size());
    check("overflow", bus.overflow, m_ovf);
  endtask

  task automatic decode(input logic r);
    int off;
    int k;
    if (r) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (bus.tx === 1'b0) begin
        rx_active = 1'b1;
        rx_t0 = cyc;
      end
    end else begin
      off = cyc - rx_t0;
      if (off >= CPB/2 && ((off - CPB/2) % CPB) == 0) begin
        k = (off - CPB/2) / CPB;
        rx_bits[k] = bus.tx;
        if (k == 9) begin
          rx_frames.push_back(rx_bits[8:1]);
          last_bits = rx_bits;
          rx_active = 1'b0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [7:0] d, input logic c);
    reset = r;
    bus.wr_en = w;
    bus.wr_data = d;
    bus.clr_ovf = c;
    @(posedge clk);
    modelStep(r, w, d, c);
    #1;
    cyc++;
    checkOutput();
    decode(r);
    reset = 1'b0;
    bus.wr_en = 1'b0;
    bus.clr_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 3000) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      n++;
    end
    check("drain_timeout", n < 3000, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int n;
    int base;
    int peak;
    logic saw_full;

    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;

    // Single 0xA5 frame: reset, push, pop into START, then the first data bit.
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].clr);
      check($sformatf("vec%0d_tx", i), bus.tx, vecs[i].exp_tx);
      check($sformatf("vec%0d_busy", i), bus.busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_full", i), bus.full, vecs[i].exp_full);
      check($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_count);
      check($sformatf("vec%0d_ovf", i), bus.overflow, vecs[i].exp_ovf);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      idle(1);
      n++;
    end
    check("a5_frame_len", n + 4, FRAME);
    check("a5_bit_centres", last_bits, 10'h34A);
    check("a5_count_end", bus.count, 0);

    // Burst of 9: first pop frees a slot, so nothing is dropped.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    base = rx_frames.size();
    peak = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i + 1), 1'b0);
      if (int'(bus.count) > peak) peak = int'(bus.count);
      if (bus.full === 1'b1) saw_full = 1'b1;
    end
    check("burst9_peak", peak, DEPTH);
    check("burst9_full_seen", saw_full, 1);
    check("burst9_ovf", bus.overflow, 0);
    drain();
    check("burst9_frames", rx_frames.size() - base, 9);
    for (int i = 0; i < 9; i++)
      if (base + i < rx_frames.size())
        check($sformatf("burst9_byte%0d", i), rx_frames[base + i], i + 1);

    // Burst of 10: the tenth write meets a full FIFO with no pop.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'(i + 1), 1'b0);
    check("burst10_ovf", bus.overflow, 1);
    drain();

    // Clear, then clear coinciding with a dropped write.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_ovf", bus.overflow, 0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    check("fill_full", bus.full, 1);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b1);
    check("clr_vs_set", bus.overflow, 1);
    drain();

    // Push on the pop cycle while one byte waits.
    base = rx_frames.size();
    applyStimulus(1'b0, 1'b1, 8'h61, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h62, 1'b0);
    idle(FRAME);
    check("pp_count_before", bus.count, 1);
    applyStimulus(1'b0, 1'b1, 8'h63, 1'b0);
    check("pp_count_after", bus.count, 1);
    drain();
    check("pp_frames", rx_frames.size() - base, 3);
    for (int i = 0; i < 3; i++)
      if (base + i < rx_frames.size())
        check($sformatf("pp_byte%0d", i), rx_frames[base + i], 8'h61 + i);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h22, 1'b0);
    check("mid_queued", bus.count, 2);
    idle(15);
    base = rx_frames.size();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    check("mid_rst_tx", bus.tx, 1);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_busy", bus.busy, 0);
    idle(100);
    check("mid_no_frames", rx_frames.size() - base, 0);

    // Spaced writes wrap both pointers twice.
    base = rx_frames.size();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
      idle(44);
    end
    drain();
    check("wrap_ovf", bus.overflow, 0);
    check("wrap_frames", rx_frames.size() - base, 20);
    for (int i = 0; i < 20; i++)
      if (base + i < rx_frames.size())
        check($sformatf("wrap_byte%0d", i), rx_frames[base + i], 8'h10 + i);

    // Random traffic against the model.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 1500; i++)
      applyStimulus(1'b0, $urandom_range(0, 9) < 3, 8'($urandom), $urandom_range(0, 29) == 0);
    drain();

    check("frames_total", rx_frames.size(), exp_frames.size());
    for (int i = 0; i < rx_frames.size() && i < exp_frames.size(); i++)
      check($sformatf("frame%0d", i), rx_frames[i], exp_frames[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_out_port.md
Name: io_out_port

Overview:
- Receiving end of the CPU's byte-output interface.
- The control path pulses `wr_en` with a byte on `wr_data` during the MOUT/ROUT store states.
- This block buffers bytes in a small FIFO and serialises them on a UART-style `tx` line (8N1, LSB first).
- The CPU never stalls on output, so the block reports `full`, and a sticky `overflow` flag records any dropped bytes.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CLKS_PER_BIT, 16, clk cycles per serial bit; at least 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  one-cycle write strobe from the CPU store state.
- wr_data  in  8  byte to output.
- clr_ovf  in  1  clears `overflow`.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a write is dropped.

Behaviour:
- Reset (synchronous, active-high, clock clk) forces:
  - tx=1, busy=0, full=0, count=0, overflow=0.
  - FIFO pointers to 0, serialiser in IDLE, bit counter and baud counter to 0.
- Reset mid-frame aborts the frame immediately; tx returns to 1 on the next edge.
- FIFO write:
  - On posedge with wr_en=1 and (not full, or a pop in the same cycle), wr_data is stored at wptr and wptr wraps modulo DEPTH.
  - Write while full with no same-cycle pop: byte dropped, overflow←1.
- Overflow flag:
  - clr_ovf=1 clears overflow.
  - If clr_ovf and an overflow event coincide, overflow ends at 1 (set wins).
- Pop: occurs only when the serialiser is in IDLE and count>0. The byte at rptr loads into the shift register and rptr advances modulo DEPTH.
- Occupancy:
  - count tracks pushes minus pops.
  - A simultaneous push and pop leaves count unchanged.
  - full = (count==DEPTH).
- Serialiser FSM (state codes live in the shared header):
  - IDLE: tx=1. If count>0, pop and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - Latency from the write edge into an empty, idle block to tx falling: 2 cycles (1 cycle to push, 1 cycle to pop and enter START). tx is registered.
  - Frame length: exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames: 1 IDLE cycle with tx=1 between STOP end and the next START.
- busy = (state!=IDLE) or (count>0), registered-consistent with state.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary. Width $clog2(CLKS_PER_BIT).
- All arithmetic is unsigned. Pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared header symbols.vh gets:
  - TX state codes: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - IO_FRAME_BITS=10.
  - IO_DEFAULT_CLKS_PER_BIT.
- One sub-module, io_fifo (sync FIFO):
  - Parameter DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - io_out_port contains io_fifo plus the serialiser FSM.

Test Plan:
1. Single byte, CLKS_PER_BIT=4: reset, then wr_en with 0xA5 for 1 cycle.
   - tx falls 2 cycles later.
   - Sampled bit centres read 0, 1,0,1,0,0,1,0,1, 1.
   - busy drops after 40 frame cycles; count returns to 0.
2. Burst fill, DEPTH=8: write 0x01..0x09 on 9 consecutive cycles.
   - Frames 0x01..0x08 emerge in order; full=1 is observed.
   - 0x09 is dropped only if no pop coincided; overflow=1 exactly when a write hits full with no pop.
   - In the normal case the first pop happens on cycle 2, so 0x09 is accepted, count peaks at 8, overflow stays 0.
   - Repeat with 10 writes: 0x0A is dropped and overflow=1.
3. Overflow clear: with overflow=1, pulse clr_ovf → overflow=0. Then assert clr_ovf in the same cycle as a full-write → overflow=1.
4. Simultaneous push/pop: count=1, serialiser returning to IDLE, wr_en on the pop cycle → count stays 1 and the next frame carries the correct byte.
5. Reset mid-frame: reset asserted during DATA bit 3 of 0x3C with 2 bytes queued.
   - Next edge: tx=1, count=0, busy=0.
   - No further frames appear until new writes.
6. Pointer wrap: 20 bytes (0x10..0x23) written at a spaced rate (one every 45 cycles) → 20 frames in order with no overflow, and rptr/wptr have wrapped twice.
